add1_pipe_arbiter: RTL and testbench



---
 rtl/add1_pipe_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_add1_pipe_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/add1_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : add1_pipe_arbiter
// Purpose  : Round-robin arbiter that feeds NUM_REQ requesters into one
//            shared fixed-latency increment pipeline. A tag shift register
//            follows each operand through the pipeline, and results land in
//            an in-order response FIFO. Credits (free FIFO slots minus
//            results still in flight) decide when the next grant is allowed.
// Options  : define ADD1_PIPE_ARBITER_STATS_EN to build per-requester
//            saturating 16-bit grant counters; otherwise grant_count is 0.
// Revision : 1.0 - initial release
// ============================================================================
module add1_pipe_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 32,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       pipe_input_valid,
  output logic [WIDTH-1:0]           pipe_x,
  input  logic                       pipe_output_valid,
  input  logic [WIDTH-1:0]           pipe_out,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]           resp_data,
  input  logic                       resp_ready,
  output logic [NUM_REQ*16-1:0]      grant_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]    DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0]  PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [IDW-1:0] LAST_INIT = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [CW-1:0]    in_flight_q, in_flight_d;
  logic [CW-1:0]    fifo_count_q, fifo_count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [IDW-1:0]   tag_q [LATENCY];
  logic [IDW-1:0]   tag_d [LATENCY];
  logic [IDW-1:0]   mem_id_q [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id_d [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_data_d [FIFO_DEPTH];

  logic             has_credit;
  logic             grant_valid;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   search_idx;
  logic             push;
  logic             pop;

  // Credit check uses only registered counts, so a pop frees a slot next cycle.
  always_comb begin
    has_credit = (({1'b0, fifo_count_q} + {1'b0, in_flight_q}) < DEPTH_EXT);
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      search_idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_valid && req_valid[search_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = search_idx;
      end
    end
    grant_valid = grant_valid && has_credit && !rst;
  end

  // One-hot ready, issue strobe and operand mux toward the shared pipeline.
  always_comb begin
    req_ready        = '0;
    pipe_x           = '0;
    pipe_input_valid = grant_valid;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_valid && (grant_idx == IDW'(i));
      if (req_ready[i]) begin
        pipe_x = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Results arriving with nothing outstanding (e.g. pre-reset leftovers) are dropped.
  always_comb begin
    push       = pipe_output_valid && (in_flight_q != '0);
    resp_valid = (fifo_count_q != '0);
    pop        = resp_valid && resp_ready;
    resp_id    = resp_valid ? mem_id_q[rd_ptr_q]   : '0;
    resp_data  = resp_valid ? mem_data_q[rd_ptr_q] : '0;
  end

  // Next-state for arbitration pointer, counters, tag pipe and FIFO.
  always_comb begin
    last_grant_d = grant_valid ? grant_idx : last_grant_q;

    case ({grant_valid, push})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase

    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end

    tag_d[0] = grant_idx;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    mem_id_d   = mem_id_q;
    mem_data_d = mem_data_q;
    if (push) begin
      mem_id_d[wr_ptr_q]   = tag_q[LATENCY-1];
      mem_data_d[wr_ptr_q] = pipe_out;
    end
  end

  // Control state with asynchronous reset; requester 0 wins first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= LAST_INIT;
      in_flight_q  <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      tag_q        <= '{default: '0};
    end else begin
      last_grant_q <= last_grant_d;
      in_flight_q  <= in_flight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tag_q        <= tag_d;
    end
  end

  // FIFO storage needs no reset: it is only observed while fifo_count is nonzero.
  always_ff @(posedge clk) begin
    mem_id_q   <= mem_id_d;
    mem_data_q <= mem_data_d;
  end

`ifdef ADD1_PIPE_ARBITER_STATS_EN
  logic [15:0] gcnt_q [NUM_REQ];
  logic [15:0] gcnt_d [NUM_REQ];

  // Saturating per-requester grant counters.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      gcnt_d[i] = gcnt_q[i];
      if (req_ready[i] && (gcnt_q[i] != 16'hFFFF)) begin
        gcnt_d[i] = gcnt_q[i] + 16'd1;
      end
      grant_count[i*16 +: 16] = gcnt_q[i];
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q <= '{default: '0};
    end else begin
      gcnt_q <= gcnt_d;
    end
  end
`else
  assign grant_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add1_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_add1_pipe_arbiter
// Purpose  : Directed self-checking bench for add1_pipe_arbiter with a
//            two-stage increment pipeline model attached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add1_pipe_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int WIDTH      = 32;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     pipe_input_valid;
  logic [WIDTH-1:0]         pipe_x;
  logic                     pipe_output_valid;
  logic [WIDTH-1:0]         pipe_out;
  logic                     resp_valid;
  logic [1:0]               resp_id;
  logic [WIDTH-1:0]         resp_data;
  logic                     resp_ready = 1'b1;
  logic [NUM_REQ*16-1:0]    grant_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Two-stage "add one" pipeline; deliberately not reset so that in-flight
  // results still emerge after a DUT reset.
  logic             v1 = 1'b0, v2 = 1'b0;
  logic [WIDTH-1:0] x1 = '0,   x2 = '0;
  always @(posedge clk) begin
    v1 <= pipe_input_valid;
    x1 <= pipe_x + 32'd1;
    v2 <= v1;
    x2 <= x1;
  end
  assign pipe_output_valid = v2;
  assign pipe_out          = x2;

  always #5 clk = ~clk;

  add1_pipe_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pipe_input_valid(pipe_input_valid), .pipe_x(pipe_x),
    .pipe_output_valid(pipe_output_valid), .pipe_out(pipe_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready), .grant_count(grant_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Operand of requester k is 0x10*(k+1); its result is that plus one.
  function automatic logic [31:0] op(input int k);
    return 32'(16 * (k + 1));
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),        64'h0);
    chk({tag, "_pipe_iv"},    64'(pipe_input_valid), 64'h0);
    chk({tag, "_pipe_x"},     64'(pipe_x),           64'h0);
    chk({tag, "_resp_valid"}, 64'(resp_valid),       64'h0);
    chk({tag, "_resp_id"},    64'(resp_id),          64'h0);
    chk({tag, "_resp_data"},  64'(resp_data),        64'h0);
    chk({tag, "_grant_cnt"},  64'(grant_count),      64'h0);
  endtask

  int e_grant [8] = '{0, 1, 2, 3, 0, -1, -1, -1};
  int e_rid   [8] = '{0, 0, 0, 0, 1, 2, 3, 0};
  bit e_rv    [8] = '{0, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    req_data = {op(3), op(2), op(1), op(0)};

    // Reset: outputs held at zero even with every requester asking.
    cyc();
    cyc();
    req_valid = 4'hF;
    #1;
    chk_all_zero("reset");

    // Round-robin with all requesters valid; responses trail by pipeline
    // latency plus the FIFO write.
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c != 0) cyc();
      if (c == 5) req_valid = '0;
      #1;
      chk($sformatf("rr_ready_c%0d", c), 64'(req_ready),
          (e_grant[c] < 0) ? 64'h0 : (64'h1 << e_grant[c]));
      chk($sformatf("rr_pipe_x_c%0d", c), 64'(pipe_x),
          (e_grant[c] < 0) ? 64'h0 : 64'(op(e_grant[c])));
      chk($sformatf("rr_resp_valid_c%0d", c), 64'(resp_valid), 64'(e_rv[c]));
      if (e_rv[c]) begin
        chk($sformatf("rr_resp_id_c%0d", c), 64'(resp_id), 64'(e_rid[c]));
        chk($sformatf("rr_resp_data_c%0d", c), 64'(resp_data), 64'(op(e_rid[c]) + 32'd1));
      end
    end
    cyc();
    #1;
    chk("rr_drained", 64'(resp_valid), 64'h0);

    // Single requester 2 with all-ones operand: result wraps to zero.
    req_valid = 4'b0100;
    req_data[2*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'h4);
    chk("wrap_pipe_x", 64'(pipe_x), 64'hFFFF_FFFF);
    cyc();
    req_valid = '0;
    req_data[2*WIDTH +: WIDTH] = op(2);
    #1;
    chk("wrap_ready_off", 64'(req_ready), 64'h0);
    cyc();
    #1;
    chk("wrap_not_yet", 64'(resp_valid), 64'h0);
    cyc();
    #1;
    chk("wrap_resp_valid", 64'(resp_valid), 64'h1);
    chk("wrap_resp_id", 64'(resp_id), 64'h2);
    chk("wrap_resp_data", 64'(resp_data), 64'h0);

    // Back-pressure: four grants (3,0,1,2) fill all credits.
    cyc();
    resp_ready = 1'b0;
    req_valid  = 4'hF;
    for (int t = 0; t < 4; t++) begin
      if (t != 0) cyc();
      #1;
      chk($sformatf("bp_grant_t%0d", t), 64'(req_ready), 64'h1 << ((3 + t) % 4));
    end
    for (int t = 4; t < 8; t++) begin
      cyc();
      #1;
      chk($sformatf("bp_stall_t%0d", t), 64'(req_ready), 64'h0);
    end
    chk("bp_head_id", 64'(resp_id), 64'h3);
    chk("bp_head_data", 64'(resp_data), 64'(op(3) + 32'd1));
    // A single pop frees one slot, but only from the following cycle.
    cyc();
    resp_ready = 1'b1;
    #1;
    chk("bp_pop_same_cycle", 64'(req_ready), 64'h0);
    cyc();
    resp_ready = 1'b0;
    #1;
    chk("bp_one_more_grant", 64'(req_ready), 64'h8);
    chk("bp_next_head_id", 64'(resp_id), 64'h0);
    cyc();
    #1;
    chk("bp_stall_again", 64'(req_ready), 64'h0);
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (8) cyc();
    #1;
    chk("bp_drained", 64'(resp_valid), 64'h0);

    // Reset with two results in flight.
    req_valid = 4'hF;
    #1;
    chk("rst_pre_g0", 64'(req_ready), 64'h1);
    cyc();
    #1;
    chk("rst_pre_g1", 64'(req_ready), 64'h2);
    cyc();
    rst = 1'b1;
    #1;
    chk_all_zero("rst_midflight");
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_post_grant", 64'(req_ready), 64'h1);
    chk("rst_post_pipe_x", 64'(pipe_x), 64'(op(0)));
    cyc();
    req_valid = '0;
    #1;
    chk("rst_no_stale_a", 64'(resp_valid), 64'h0);
    cyc();
    #1;
    chk("rst_no_stale_b", 64'(resp_valid), 64'h0);
    cyc();
    #1;
    chk("rst_new_resp_valid", 64'(resp_valid), 64'h1);
    chk("rst_new_resp_id", 64'(resp_id), 64'h0);
    chk("rst_new_resp_data", 64'(resp_data), 64'(op(0) + 32'd1));

`ifdef ADD1_PIPE_ARBITER_STATS_EN
    // One grant to requester 0 since reset, then saturate requester 1.
    chk("stats_after_reset", 64'(grant_count), 64'h1);
    req_valid = 4'b0010;
    repeat (70000) cyc();
    req_valid = '0;
    #1;
    chk("stats_saturated", 64'(grant_count[31:16]), 64'hFFFF);
    chk("stats_req0", 64'(grant_count[15:0]), 64'h1);
`else
    chk("stats_disabled", 64'(grant_count), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
